conv_requant: RTL and testbench

//  Requantization stage directly downstream of the conv bias-add stage. Takes biased 32-bit

---
 rtl/conv_requant.sv | 165 ++++++++++++++++
 tb/tb_conv_requant.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_requant.sv
// conv_requant: per-channel scale, rounding right-shift, zero point, optional ReLU and int8 saturation.
// Latency: 4 register stages (S0 capture, S1 multiply, S2 round/shift, S3 clamp/output register).
// Backpressure: the whole pipeline freezes while M_Valid && !M_Ready; S_Ready is combinational.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   Next_Reg         new-layer pulse, clears the beat counter
//   S_Data/S_Valid/S_Ready   biased accumulators in, lane k = j*PICTURE_NUM + i (channel j, picture i)
//   scale_data_in    signed per-channel multiplier, shift_data_in per-channel right shift
//   Zero_Point_REG, Relu_En_REG   output zero point and ReLU enable
//   Beat_Num_REG     beats per layer (0 = never done)
//   M_Data/M_Valid/M_Ready   int8 results out, same lane order
//   Frame_Done       1-cycle pulse after the last beat of a layer
module conv_requant #(
  parameter int PICTURE_NUM     = 2,
  parameter int CHANNEL_OUT_NUM = 8,
  parameter int WIDTH_DATA_ADD  = 32,
  parameter int WIDTH_SHIFT     = 6,
  parameter int WIDTH_DATA_OUT  = 8,
  parameter int WIDTH_BEAT_CNT  = 20
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 Next_Reg,
  input  logic [PICTURE_NUM*CHANNEL_OUT_NUM*WIDTH_DATA_ADD-1:0] S_Data,
  input  logic                                                 S_Valid,
  output logic                                                 S_Ready,
  input  logic [CHANNEL_OUT_NUM*WIDTH_DATA_ADD-1:0]             scale_data_in,
  input  logic [CHANNEL_OUT_NUM*WIDTH_SHIFT-1:0]                shift_data_in,
  input  logic [WIDTH_DATA_OUT-1:0]                            Zero_Point_REG,
  input  logic                                                 Relu_En_REG,
  input  logic [WIDTH_BEAT_CNT-1:0]                            Beat_Num_REG,
  output logic [PICTURE_NUM*CHANNEL_OUT_NUM*WIDTH_DATA_OUT-1:0] M_Data,
  output logic                                                 M_Valid,
  input  logic                                                 M_Ready,
  output logic                                                 Frame_Done
);

  localparam int LANES = PICTURE_NUM * CHANNEL_OUT_NUM;
  localparam int WP    = 2 * WIDTH_DATA_ADD;  // full product
  localparam int WR    = WP + 1;              // product plus rounding constant
  localparam int WV    = WP + 2;              // rounded value plus zero point
  localparam logic signed [WIDTH_DATA_OUT-1:0] OUT_MIN = {1'b1, {(WIDTH_DATA_OUT-1){1'b0}}};
  localparam logic signed [WIDTH_DATA_OUT-1:0] OUT_MAX = {1'b0, {(WIDTH_DATA_OUT-1){1'b1}}};

  // Per-beat settings that ride along with the data after S0.
  typedef struct packed {
    logic [CHANNEL_OUT_NUM*WIDTH_SHIFT-1:0] shift;
    logic signed [WIDTH_DATA_OUT-1:0]       zp;
    logic                                   relu;
  } cfg_t;

  // Round half toward +inf, then arithmetic shift. The extra bit keeps
  // p + 2^(sh-1) from wrapping when p is near the top of its range.
  function automatic logic signed [WR-1:0] round_shift(input logic signed [WP-1:0]    p,
                                                       input logic [WIDTH_SHIFT-1:0] sh);
    logic signed [WR-1:0] sum;
    sum = WR'(p);
    if (sh != '0) begin
      sum = sum + (WR'(1) << (sh - WIDTH_SHIFT'(1)));
      sum = sum >>> sh;
    end
    return sum;
  endfunction

  function automatic logic [WIDTH_DATA_OUT-1:0] zp_clamp(input logic signed [WR-1:0]             r,
                                                         input logic signed [WIDTH_DATA_OUT-1:0] zp,
                                                         input logic                             relu);
    logic signed [WV-1:0] v;
    logic signed [WV-1:0] lo;
    logic signed [WV-1:0] hi;
    v  = WV'(r) + WV'(zp);
    lo = relu ? WV'(zp) : WV'(OUT_MIN);
    hi = WV'(OUT_MAX);
    if (v < lo)      v = lo;
    else if (v > hi) v = hi;
    return v[WIDTH_DATA_OUT-1:0];
  endfunction

  logic                              en;
  logic                              s0_vld, s1_vld, s2_vld;
  logic signed [WIDTH_DATA_ADD-1:0]  s0_acc   [LANES];
  logic signed [WIDTH_DATA_ADD-1:0]  s0_scale [CHANNEL_OUT_NUM];
  cfg_t                              s0_cfg, s1_cfg, s2_cfg;
  logic signed [WP-1:0]              s1_prod  [LANES];
  logic signed [WP-1:0]              prod_nxt [LANES];
  logic signed [WR-1:0]              s2_rnd   [LANES];
  logic signed [WR-1:0]              rnd_nxt  [LANES];
  logic [LANES*WIDTH_DATA_OUT-1:0]   out_nxt;
  logic [WIDTH_BEAT_CNT-1:0]         beat_cnt;
  logic                              out_hs;
  logic                              last_beat;

  assign en      = !M_Valid || M_Ready;
  assign S_Ready = en;

  always_comb begin
    out_nxt = '0;
    for (int k = 0; k < LANES; k++) begin
      prod_nxt[k] = WP'(s0_acc[k]) * WP'(s0_scale[k / PICTURE_NUM]);
      rnd_nxt[k]  = round_shift(s1_prod[k],
                                s1_cfg.shift[(k / PICTURE_NUM)*WIDTH_SHIFT +: WIDTH_SHIFT]);
      out_nxt[k*WIDTH_DATA_OUT +: WIDTH_DATA_OUT] = zp_clamp(s2_rnd[k], s2_cfg.zp, s2_cfg.relu);
    end
  end

  // Bubbles advance like beats: every stage loads whenever en is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_vld  <= 1'b0;
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      M_Valid <= 1'b0;
      M_Data  <= '0;
      s0_cfg  <= '0;
      s1_cfg  <= '0;
      s2_cfg  <= '0;
      for (int k = 0; k < LANES; k++) begin
        s0_acc[k]  <= '0;
        s1_prod[k] <= '0;
        s2_rnd[k]  <= '0;
      end
      for (int j = 0; j < CHANNEL_OUT_NUM; j++) s0_scale[j] <= '0;
    end else if (en) begin
      s0_vld <= S_Valid;
      for (int k = 0; k < LANES; k++) s0_acc[k] <= S_Data[k*WIDTH_DATA_ADD +: WIDTH_DATA_ADD];
      for (int j = 0; j < CHANNEL_OUT_NUM; j++)
        s0_scale[j] <= scale_data_in[j*WIDTH_DATA_ADD +: WIDTH_DATA_ADD];
      s0_cfg  <= '{shift: shift_data_in, zp: Zero_Point_REG, relu: Relu_En_REG};
      s1_vld  <= s0_vld;
      s1_prod <= prod_nxt;
      s1_cfg  <= s0_cfg;
      s2_vld  <= s1_vld;
      s2_rnd  <= rnd_nxt;
      s2_cfg  <= s1_cfg;
      M_Valid <= s2_vld;
      M_Data  <= out_nxt;
    end
  end

  assign out_hs    = M_Valid && M_Ready;
  assign last_beat = (Beat_Num_REG != '0) && (beat_cnt == Beat_Num_REG - WIDTH_BEAT_CNT'(1));

  // Next_Reg outranks a same-cycle output handshake, including any Frame_Done it would raise.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt   <= '0;
      Frame_Done <= 1'b0;
    end else if (Next_Reg) begin
      beat_cnt   <= '0;
      Frame_Done <= 1'b0;
    end else if (out_hs) begin
      if (last_beat) begin
        beat_cnt   <= '0;
        Frame_Done <= 1'b1;
      end else begin
        beat_cnt   <= beat_cnt + WIDTH_BEAT_CNT'(1);
        Frame_Done <= 1'b0;
      end
    end else begin
      Frame_Done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_requant.sv
// tb_conv_requant: directed vectors, stall/reset/layer sequences and random traffic for conv_requant.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Expected beats come from an arithmetic reference model kept in a queue.
module tb_conv_requant;
  localparam int P  = 2;
  localparam int C  = 8;
  localparam int WA = 32;
  localparam int WS = 6;
  localparam int WO = 8;
  localparam int WB = 20;
  localparam int L  = P * C;

  logic            clk = 1'b0;
  logic            rst, next_reg, s_valid, s_ready, relu, m_valid, m_ready, frame_done;
  logic [L*WA-1:0] s_data;
  logic [C*WA-1:0] scale;
  logic [C*WS-1:0] shift;
  logic [7:0]      zp;
  logic [WB-1:0]   beat_num;
  logic [L*WO-1:0] m_data;

  int checks = 0;
  int errors = 0;

  logic [L*WO-1:0] expq[$];
  int              beats_in_layer;
  logic            fd_exp;
  int              fd_pulses;
  logic            in_hs;

  always #5 clk = ~clk;

  conv_requant dut (
    .clk(clk), .rst(rst), .Next_Reg(next_reg),
    .S_Data(s_data), .S_Valid(s_valid), .S_Ready(s_ready),
    .scale_data_in(scale), .shift_data_in(shift),
    .Zero_Point_REG(zp), .Relu_En_REG(relu), .Beat_Num_REG(beat_num),
    .M_Data(m_data), .M_Valid(m_valid), .M_Ready(m_ready), .Frame_Done(frame_done)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: exact product, floor((p + 2^(sh-1)) / 2^sh) by integer division, add ZP, clamp.
  function automatic logic [7:0] model_lane(input logic signed [31:0] a, input logic signed [31:0] sc,
                                            input int sh, input logic signed [7:0] z, input logic r);
    logic signed [127:0] x, d, q, lo;
    x = a;
    d = sc;
    x = x * d;
    if (sh > 0) begin
      x = x + (128'sd1 <<< (sh - 1));
      d = 128'sd1 <<< sh;
      q = x / d;
      if (x < 0 && q * d != x) q = q - 1;
    end else begin
      q = x;
    end
    q  = q + z;
    lo = r ? 128'(z) : -128'sd128;
    if (q < lo) q = lo;
    if (q > 128'sd127) q = 128'sd127;
    return q[7:0];
  endfunction

  function automatic logic [L*WO-1:0] model_beat(input logic [L*WA-1:0] d, input logic [C*WA-1:0] sc,
                                                 input logic [C*WS-1:0] sh, input logic [7:0] z,
                                                 input logic r);
    logic [L*WO-1:0] res;
    int j;
    res = '0;
    for (int k = 0; k < L; k++) begin
      j = k / P;
      res[k*WO +: WO] = model_lane(d[k*WA +: WA], sc[j*WA +: WA], int'(sh[j*WS +: WS]), z, r);
    end
    return res;
  endfunction

  // One clock cycle: settle, score handshakes and Frame_Done, then advance to edge + 1.
  task automatic tick;
    logic            fd_next;
    logic [L*WO-1:0] e;
    int              bn;
    #1;
    in_hs   = 1'b0;
    fd_next = 1'b0;
    bn      = int'(beat_num);
    if (rst) begin
      expq.delete();
      beats_in_layer = 0;
    end else begin
      check("frame_done", frame_done, fd_exp);
      if (frame_done) fd_pulses++;
      if (m_valid && m_ready) begin
        if (expq.size() == 0) check("spurious_beat", m_valid, 1'b0);
        else begin
          e = expq.pop_front();
          check("m_data", m_data, e);
        end
        if (next_reg) beats_in_layer = 0;
        else begin
          beats_in_layer++;
          if (bn != 0 && beats_in_layer % bn == 0) fd_next = 1'b1;
        end
      end else if (next_reg) begin
        beats_in_layer = 0;
      end
      if (s_valid && s_ready) begin
        in_hs = 1'b1;
        expq.push_back(model_beat(s_data, scale, shift, zp, relu));
      end
    end
    fd_exp = fd_next;
    @(posedge clk);
    #1;
  endtask

  task automatic set_uniform(input logic signed [31:0] a, input logic signed [31:0] sc, input int sh,
                             input logic signed [7:0] z, input logic r);
    for (int k = 0; k < L; k++) s_data[k*WA +: WA] = a;
    for (int j = 0; j < C; j++) begin
      scale[j*WA +: WA] = sc;
      shift[j*WS +: WS] = sh[5:0];
    end
    zp   = z;
    relu = r;
  endtask

  task automatic set_rand_beat;
    int mode;
    mode = $urandom_range(0, 2);
    for (int k = 0; k < L; k++)
      s_data[k*WA +: WA] = (mode == 0) ? $urandom_range(0, 4000) - 2000 : $urandom;
    for (int j = 0; j < C; j++) begin
      if (mode == 0) begin
        scale[j*WA +: WA] = $urandom_range(0, 600) - 300;
        shift[j*WS +: WS] = 6'($urandom_range(0, 8));
      end else if (mode == 1) begin
        scale[j*WA +: WA] = $urandom;
        shift[j*WS +: WS] = 6'($urandom_range(28, 63));
      end else begin
        scale[j*WA +: WA] = $urandom_range(0, 65536);
        shift[j*WS +: WS] = 6'($urandom_range(20, 50));
      end
    end
    zp   = 8'($urandom);
    relu = ($urandom_range(0, 3) == 0);
  endtask

  // Present the current beat once and count rising edges (including the accepting one) to M_Valid.
  task automatic send_one(input string name);
    int n;
    s_valid = 1'b1;
    tick();
    check({name, "_accept"}, in_hs, 1'b1);
    s_valid = 1'b0;
    n = 1;
    while (!m_valid && n < 12) begin
      tick();
      n++;
    end
    check({name, "_latency"}, n, 4);
  endtask

  task automatic drain(input string name);
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 30 && expq.size() != 0; i++) tick();
    tick();
    tick();
    check({name, "_drained"}, expq.size(), 0);
  endtask

  task automatic stream(input string name, input int n);
    int b;
    b       = 0;
    m_ready = 1'b1;
    s_valid = 1'b1;
    set_rand_beat();
    for (int c = 0; c < n + 40 && b < n; c++) begin
      tick();
      if (in_hs) begin
        b++;
        if (b < n) set_rand_beat();
        else s_valid = 1'b0;
      end
    end
    check({name, "_accepted"}, b, n);
    drain(name);
  endtask

  task automatic pulse_next;
    next_reg = 1'b1;
    tick();
    next_reg = 1'b0;
  endtask

  typedef struct {
    logic signed [31:0] acc;
    logic signed [31:0] scl;
    int                 sh;
    logic signed [7:0]  zp;
    logic               relu;
    logic signed [7:0]  exp;
  } vec_t;

  vec_t vecs[17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [L*WO-1:0] exp_v;
    int              b;

    vecs[0]  = '{32'sd3, 32'sd1, 1, 8'sd0, 1'b0, 8'sd2};
    vecs[1]  = '{-32'sd3, 32'sd1, 1, 8'sd0, 1'b0, -8'sd1};
    vecs[2]  = '{32'sd100, 32'sd1073741824, 31, 8'sd0, 1'b0, 8'sd50};
    vecs[3]  = '{32'sd1000, 32'sd1, 0, 8'sd0, 1'b0, 8'sd127};
    vecs[4]  = '{-32'sd1000, 32'sd1, 0, 8'sd0, 1'b0, -8'sd128};
    vecs[5]  = '{-32'sd50, 32'sd1, 0, -8'sd5, 1'b1, -8'sd5};
    vecs[6]  = '{-32'sd5, 32'sd1, 1, 8'sd0, 1'b0, -8'sd2};
    vecs[7]  = '{32'sd20, 32'sd3, 2, 8'sd10, 1'b0, 8'sd25};
    vecs[8]  = '{32'sh8000_0000, 32'sh8000_0000, 63, 8'sd0, 1'b0, 8'sd1};
    vecs[9]  = '{32'sh7fff_ffff, 32'sh7fff_ffff, 62, 8'sd0, 1'b0, 8'sd1};
    vecs[10] = '{32'sd50, 32'sd1, 0, 8'sd100, 1'b1, 8'sd127};
    vecs[11] = '{-32'sd300, 32'sd1, 0, 8'sd127, 1'b1, 8'sd127};
    vecs[12] = '{32'sh8000_0000, 32'sd1, 0, -8'sd100, 1'b0, -8'sd128};
    vecs[13] = '{32'sd1, 32'sd1, 1, 8'sd0, 1'b0, 8'sd1};
    vecs[14] = '{-32'sd1, 32'sd1, 1, 8'sd0, 1'b0, 8'sd0};
    vecs[15] = '{32'sd30, 32'sd1, 0, -8'sd128, 1'b1, -8'sd98};
    vecs[16] = '{-32'sd7, -32'sd9, 0, 8'sd3, 1'b0, 8'sd66};

    rst = 1'b1; next_reg = 1'b0; s_valid = 1'b0; m_ready = 1'b1; beat_num = '0;
    s_data = '0; scale = '0; shift = '0; zp = '0; relu = 1'b0;
    beats_in_layer = 0; fd_exp = 1'b0; fd_pulses = 0; in_hs = 1'b0;
    m_ready = 1'b0;
    tick();
    tick();
    check("reset_m_valid", m_valid, 1'b0);
    check("reset_m_data", m_data, '0);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_s_ready", s_ready, 1'b1);
    rst = 1'b0;
    m_ready = 1'b1;

    // Directed single-beat vectors, every lane identical.
    for (int i = 0; i < 17; i++) begin
      set_uniform(vecs[i].acc, vecs[i].scl, vecs[i].sh, vecs[i].zp, vecs[i].relu);
      send_one($sformatf("vec%0d", i));
      exp_v = {L{vecs[i].exp}};
      check($sformatf("vec%0d_data", i), m_data, exp_v);
      tick();
    end
    drain("vectors");

    // Distinct per-channel scales: lane j*P+i must carry 10*(j+1).
    set_uniform(32'sd10, 32'sd1, 0, 8'sd0, 1'b0);
    for (int j = 0; j < C; j++) scale[j*WA +: WA] = j + 1;
    for (int k = 0; k < L; k++) exp_v[k*WO +: WO] = 8'(10 * (k / P + 1));
    send_one("chan_scale");
    check("chan_scale_data", m_data, exp_v);
    tick();
    drain("chan_scale");

    // Six beats offered against a stalled sink: exactly four fit.
    m_ready = 1'b0;
    s_valid = 1'b1;
    set_rand_beat();
    b = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (in_hs) begin
        b++;
        if (b < 6) set_rand_beat();
        else s_valid = 1'b0;
      end
    end
    check("stall_accepted", b, 4);
    check("stall_s_ready", s_ready, 1'b0);
    check("stall_m_valid", m_valid, 1'b1);
    m_ready = 1'b1;
    for (int c = 0; c < 40 && (b < 6 || expq.size() != 0); c++) begin
      tick();
      if (in_hs) begin
        b++;
        if (b < 6) set_rand_beat();
        else s_valid = 1'b0;
      end
    end
    check("stall_total", b, 6);
    drain("stall");

    // Layer of 6 beats: two pulses over 12 beats; Next_Reg restarts the count.
    beat_num = 20'd6;
    pulse_next();
    fd_pulses = 0;
    stream("layer12", 12);
    check("layer12_pulses", fd_pulses, 2);
    stream("partial3", 3);
    pulse_next();
    fd_pulses = 0;
    stream("after_next", 6);
    check("after_next_pulses", fd_pulses, 1);

    // Reset with three beats in flight and a partly counted layer.
    stream("pre_rst", 2);
    s_valid = 1'b1;
    set_rand_beat();
    b = 0;
    for (int c = 0; c < 10 && b < 3; c++) begin
      tick();
      if (in_hs) begin
        b++;
        set_rand_beat();
      end
    end
    s_valid = 1'b0;
    check("inflight_accepted", b, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_m_valid", m_valid, 1'b0);
    check("midrst_m_data", m_data, '0);
    check("midrst_frame_done", frame_done, 1'b0);
    fd_pulses = 0;
    set_rand_beat();
    send_one("post_rst");
    tick();
    stream("post_rst_rest", 5);
    check("post_rst_pulses", fd_pulses, 1);

    // Random traffic with random backpressure and occasional layer restarts.
    beat_num = 20'd5;
    pulse_next();
    s_valid = 1'b1;
    set_rand_beat();
    for (int c = 0; c < 400; c++) begin
      m_ready  = ($urandom_range(0, 9) < 6);
      next_reg = ($urandom_range(0, 29) == 0);
      tick();
      if (in_hs || !s_valid) begin
        s_valid = ($urandom_range(0, 9) < 7);
        set_rand_beat();
      end
    end
    next_reg = 1'b0;
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
